// File: rtl/ad56x3_serial_rx.sv
// ad56x3_serial_rx
// Receiver for the AD5623/AD5643/AD5663 3-wire serial protocol (SYNC/SCLK/DIN).
// It oversamples the serial lines in the clk domain, collects 24-bit frames,
// decodes command/address/data and presents per-channel words with
// single-cycle valid strobes. Aborted or rejected frames raise frameErr.
module ad56x3_serial_rx #(
  parameter logic SIGN_A      = 1'b0,
  parameter logic SIGN_B      = 1'b0,
  parameter int   DATA_WIDTH  = 14,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dacSync,
  input  logic                  dacSclk,
  input  logic                  dacDin,
  output logic [DATA_WIDTH-1:0] dataA,
  output logic [DATA_WIDTH-1:0] dataB,
  output logic                  validA,
  output logic                  validB,
  output logic [2:0]            command,
  output logic                  frameErr
);

  // Only the three real DAC resolutions and a non-empty synchronizer are legal.
  if (!(DATA_WIDTH == 12 || DATA_WIDTH == 14 || DATA_WIDTH == 16)) begin : g_bad_width
    $fatal(1, "ad56x3_serial_rx: DATA_WIDTH must be 12, 14 or 16");
  end
  if (SYNC_STAGES < 1) begin : g_bad_sync
    $fatal(1, "ad56x3_serial_rx: SYNC_STAGES must be at least 1");
  end

  localparam int FRAME_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT
  } state_t;

  // Command field values that carry a data word.
  localparam logic [2:0] CMD_WR_INPUT   = 3'b000;
  localparam logic [2:0] CMD_WR_UPD_DAC = 3'b010;
  localparam logic [2:0] CMD_WR_UPD     = 3'b011;

  // Address field values.
  localparam logic [2:0] ADDR_A    = 3'b000;
  localparam logic [2:0] ADDR_B    = 3'b001;
  localparam logic [2:0] ADDR_BOTH = 3'b111;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic cmd_accepted(input logic [2:0] cmd);
    return (cmd == CMD_WR_INPUT) || (cmd == CMD_WR_UPD_DAC) || (cmd == CMD_WR_UPD);
  endfunction

  function automatic logic addr_accepted(input logic [2:0] addr);
    return (addr == ADDR_A) || (addr == ADDR_B) || (addr == ADDR_BOTH);
  endfunction

  // Signed channels were offset-binary converted by the transmitter (MSB
  // inverted); flipping the MSB back restores two's complement.
  function automatic logic [DATA_WIDTH-1:0] recover(input logic [DATA_WIDTH-1:0] field,
                                                    input logic                  sign);
    return {field[DATA_WIDTH-1] ^ sign, field[DATA_WIDTH-2:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] syncChain_q;
  logic [SYNC_STAGES-1:0] sclkChain_q;
  logic [SYNC_STAGES-1:0] dinChain_q;
  logic                   syncPrev_q;
  logic                   sclkPrev_q;
  logic                   sSync;
  logic                   sSclk;
  logic                   sDin;
  logic                   syncFall;
  logic                   sclkFall;

  // Synchronizer chains; the SYNC chain resets low so a SYNC held low across
  // reset release never produces a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      syncChain_q <= '0;
      sclkChain_q <= '1;
      dinChain_q  <= '0;
      syncPrev_q  <= 1'b0;
      sclkPrev_q  <= 1'b1;
    end else begin
      syncChain_q <= (syncChain_q << 1) | SYNC_STAGES'(dacSync);
      sclkChain_q <= (sclkChain_q << 1) | SYNC_STAGES'(dacSclk);
      dinChain_q  <= (dinChain_q << 1) | SYNC_STAGES'(dacDin);
      syncPrev_q  <= sSync;
      sclkPrev_q  <= sSclk;
    end
  end

  assign sSync    = syncChain_q[SYNC_STAGES-1];
  assign sSclk    = sclkChain_q[SYNC_STAGES-1];
  assign sDin     = dinChain_q[SYNC_STAGES-1];
  assign syncFall = syncPrev_q & ~sSync;
  assign sclkFall = sclkPrev_q & ~sSclk;

  // ---------------------------------------------------------------------------
  // Frame FSM and decode
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   dataA_q, dataA_d;
  logic [DATA_WIDTH-1:0]   dataB_q, dataB_d;
  logic [2:0]              cmd_q, cmd_d;
  logic                    validA_q, validA_d;
  logic                    validB_q, validB_d;
  logic                    frameErr_q, frameErr_d;

  // The word as it stands once the bit arriving on this edge is included.
  logic [FRAME_BITS-1:0]   frameWord;
  logic [2:0]              frameCmd;
  logic [2:0]              frameAddr;
  logic [DATA_WIDTH-1:0]   frameField;
  logic                    lastEdge;
  logic                    unused_bits;

  assign frameWord   = {shift_q[FRAME_BITS-2:0], sDin};
  assign frameCmd    = frameWord[21:19];
  assign frameAddr   = frameWord[18:16];
  assign frameField  = frameWord[15 -: DATA_WIDTH];
  assign lastEdge    = sclkFall && (cnt_q == 5'(FRAME_BITS - 1));
  assign unused_bits = ^{shift_q, frameWord};

  // State register and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      dataA_q    <= '0;
      dataB_q    <= '0;
      cmd_q      <= '0;
      validA_q   <= 1'b0;
      validB_q   <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      dataA_q    <= dataA_d;
      dataB_q    <= dataB_d;
      cmd_q      <= cmd_d;
      validA_q   <= validA_d;
      validB_q   <= validB_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Next-state logic: collect bits, then accept, reject or abort the frame.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    dataA_d    = dataA_q;
    dataB_d    = dataB_q;
    cmd_d      = cmd_q;
    validA_d   = 1'b0;
    validB_d   = 1'b0;
    frameErr_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (syncFall) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (sclkFall) begin
          shift_d = frameWord;
          cnt_d   = cnt_q + 5'd1;
        end
        // A final edge coinciding with SYNC rising still completes the frame.
        if (lastEdge) begin
          state_d = ST_WAIT;
          if (cmd_accepted(frameCmd) && addr_accepted(frameAddr)) begin
            cmd_d = frameCmd;
            if (frameAddr == ADDR_A || frameAddr == ADDR_BOTH) begin
              dataA_d  = recover(frameField, SIGN_A);
              validA_d = 1'b1;
            end
            if (frameAddr == ADDR_B || frameAddr == ADDR_BOTH) begin
              dataB_d  = recover(frameField, SIGN_B);
              validB_d = 1'b1;
            end
          end else begin
            frameErr_d = 1'b1;
          end
        end else if (sSync) begin
          frameErr_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (sSync) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dataA    = dataA_q;
  assign dataB    = dataB_q;
  assign validA   = validA_q;
  assign validB   = validB_q;
  assign command  = cmd_q;
  assign frameErr = frameErr_q;

endmodule

// File: tb/tb_ad56x3_serial_rx.sv
// tb_ad56x3_serial_rx
// Bench for ad56x3_serial_rx (DATA_WIDTH=14, SIGN_A=1, SIGN_B=0, SYNC_STAGES=2).
// A bit-banged driver sends frames with sclk = clk/4; expected strobe events
// are queued as frames are sent and checked when the DUT raises a strobe.
module tb_ad56x3_serial_rx;

  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          dacSync;
  logic          dacSclk;
  logic          dacDin;
  logic [DW-1:0] dataA;
  logic [DW-1:0] dataB;
  logic          validA;
  logic          validB;
  logic [2:0]    command;
  logic          frameErr;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          va;
    logic          vb;
    logic          err;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    cmd;
  } exp_t;

  typedef struct {
    logic [23:0] frame;
    exp_t        e;
  } vec_t;

  exp_t exp_q[$];

  ad56x3_serial_rx #(
    .SIGN_A     (1'b1),
    .SIGN_B     (1'b0),
    .DATA_WIDTH (DW),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .dacSync (dacSync),
    .dacSclk (dacSclk),
    .dacDin  (dacDin),
    .dataA   (dataA),
    .dataB   (dataB),
    .validA  (validA),
    .validB  (validB),
    .command (command),
    .frameErr(frameErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic va, input logic vb, input logic err,
                              input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [2:0] cmd);
    exp_t e;
    e.va = va; e.vb = vb; e.err = err; e.a = a; e.b = b; e.cmd = cmd;
    return e;
  endfunction

  // Scoreboard: every strobe cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (validA === 1'b1 || validB === 1'b1 || frameErr === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'({validA, validB, frameErr}), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("strobes", 32'({validA, validB, frameErr}), 32'({e.va, e.vb, e.err}));
        chk("dataA", 32'(dataA), 32'(e.a));
        chk("dataB", 32'(dataB), 32'(e.b));
        chk("command", 32'(command), 32'(e.cmd));
      end
    end
  end

  // Sends nbits of f MSB first, then extra sclk cycles, then raises SYNC.
  // If rst_at is reached, reset is pulsed before that bit while SYNC stays low.
  task automatic send_frame(input logic [23:0] f, input int nbits, input int extra,
                            input int rst_at);
    @(negedge clk);
    dacSclk = 1'b1;
    dacSync = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
      dacDin  = f[23-i];
      dacSclk = 1'b1;
      repeat (2) @(negedge clk);
      dacSclk = 1'b0;
      repeat (2) @(negedge clk);
    end
    for (int i = 0; i < extra; i++) begin
      dacSclk = 1'b1;
      repeat (2) @(negedge clk);
      dacSclk = 1'b0;
      repeat (2) @(negedge clk);
    end
    dacSclk = 1'b1;
    dacSync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];

    vecs[0] = '{24'h007FFC, mk(1, 0, 0, 14'h3FFF, 14'h0000, 3'b000)};
    vecs[1] = '{24'h1148D0, mk(0, 1, 0, 14'h3FFF, 14'h1234, 3'b010)};
    vecs[2] = '{24'h1F0000, mk(1, 1, 0, 14'h2000, 14'h0000, 3'b011)};
    vecs[3] = '{24'h120000, mk(0, 0, 1, 14'h2000, 14'h0000, 3'b011)};
    vecs[4] = '{24'h380000, mk(0, 0, 1, 14'h2000, 14'h0000, 3'b011)};
    vecs[5] = '{24'hC1ABCD, mk(0, 1, 0, 14'h2000, 14'h2AF3, 3'b000)};
    vecs[6] = '{24'h18FFFF, mk(1, 0, 0, 14'h1FFF, 14'h2AF3, 3'b011)};
    vecs[7] = '{24'h040000, mk(0, 0, 1, 14'h1FFF, 14'h2AF3, 3'b011)};

    reset   = 1'b1;
    dacSync = 1'b1;
    dacSclk = 1'b1;
    dacDin  = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    chk("reset_dataA", 32'(dataA), 32'h0);
    chk("reset_dataB", 32'(dataB), 32'h0);
    chk("reset_command", 32'(command), 32'h0);
    chk("reset_strobes", 32'({validA, validB, frameErr}), 32'h0);

    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(vecs[i].e);
      send_frame(vecs[i].frame, 24, 0, -1);
    end

    // Aborted frame after 10 bits, then a good frame.
    exp_q.push_back(mk(0, 0, 1, 14'h1FFF, 14'h2AF3, 3'b011));
    send_frame(24'h1148D0, 10, 0, -1);
    exp_q.push_back(mk(1, 0, 0, 14'h3FFF, 14'h2AF3, 3'b000));
    send_frame(24'h007FFC, 24, 0, -1);

    // Extra sclk edges after a complete frame are ignored.
    exp_q.push_back(mk(0, 1, 0, 14'h3FFF, 14'h1234, 3'b010));
    send_frame(24'h1148D0, 24, 5, -1);

    // Reset after bit 12 with SYNC held low: the rest of the frame is ignored.
    send_frame(24'h1F0000, 24, 0, 12);
    chk("midreset_dataA", 32'(dataA), 32'h0);
    chk("midreset_dataB", 32'(dataB), 32'h0);
    chk("midreset_command", 32'(command), 32'h0);
    chk("midreset_pending", 32'(exp_q.size()), 32'h0);

    exp_q.push_back(mk(1, 0, 0, 14'h3FFF, 14'h0000, 3'b000));
    send_frame(24'h007FFC, 24, 0, -1);

    repeat (20) @(negedge clk);
    chk("pending_events", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ad56x3_serial_rx.md
Name: ad56x3_serial_rx

Overview:
Synthesizable receiver for the AD5623/AD5643/AD5663 3-wire serial protocol (SYNC/SCLK/DIN, 24-bit frames). It decodes the frames that the team's DAC driver produces and recovers the per-channel data words. Use cases are FPGA-to-FPGA links that emulate the DAC, and on-chip loopback checking of the DAC driver. The block oversamples the serial lines in the `clk` domain and presents parallel channel A/B data with single-cycle valid strobes.

Parameters:
- SIGN_A, 1'b0, 1 = channel A data is signed: the transmitter inverted the MSB, so the receiver re-inverts it. 0 = unsigned, passed through.
- SIGN_B, 1'b0, same as SIGN_A for channel B.
- DATA_WIDTH, 14, DAC resolution: 12, 14 or 16. Other values are a fatal elaboration error.
- SYNC_STAGES, 2, synchronizer depth on dacSync/dacSclk/dacDin. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dacSync  in  1  frame select, active low.
- dacSclk  in  1  serial clock; data is sampled on its falling edge.
- dacDin  in  1  serial data, MSB first.
- dataA  out  DATA_WIDTH  last accepted channel A value.
- dataB  out  DATA_WIDTH  last accepted channel B value.
- validA  out  1  1-cycle pulse when dataA is updated.
- validB  out  1  1-cycle pulse when dataB is updated.
- command  out  3  command field of the last accepted frame.
- frameErr  out  1  1-cycle pulse on an aborted or rejected frame.

Behaviour:

Reset (synchronous, all registers):
- dataA = dataB = 0, command = 0; validA, validB and frameErr = 0.
- FSM goes to IDLE; bit counter = 0; shift register = 0.
- Synchronizer flops: dacSync chain to 0, dacSclk chain to 1, dacDin chain to 0.
- Because the dacSync chain resets low, a dacSync held low through reset release never looks like a frame start.

Input conditioning:
- Each input passes through SYNC_STAGES flops, giving sSync/sSclk/sDin.
- A falling edge is the registered previous sample = 1 and the current sample = 0, computed separately for sSync and sSclk.
- Each dacSclk level must be stable for at least 1 clk cycle when the source runs on the same `clk`, and at least 2 cycles when the source is asynchronous. Narrower pulses are out of spec.

FSM:
- IDLE: on an sSync falling edge, clear the bit counter and go to SHIFT. All sSclk edges are ignored in IDLE.
- SHIFT, sSclk falling edge: shift sDin into the LSB of the 24-bit shift register and increment the counter.
- SHIFT, 24th falling edge: decode the frame (the value shifted in on this edge is included) and go to WAIT.
- SHIFT, sSync returns to 1 before the 24th edge (edge and rising sync in the same cycle count as the edge arriving first): pulse frameErr, leave outputs unchanged, go to IDLE.
- WAIT: further sSclk edges are ignored and no error is raised. When sSync = 1, go to IDLE.
- There is no minimum SYNC-high time: IDLE can see a new frame start 1 cycle after entering.

Decode (frame bits [23:0], bit 23 first on the wire):
- [23:22] don't care.
- [21:19] command. Accepted values: 000 write input register, 010 write and update DAC, 011 write and update.
- [18:16] address: 000 = A, 001 = B, 111 = both.
- [15:16-DATA_WIDTH] data field. Lower bits are ignored.
- Recovered value = {field MSB ^ SIGN_x, remaining field bits}.
- Any other command or address: pulse frameErr and leave dataA/dataB/command unchanged.

Latency and output rules:
- Registered outputs update, and valid pulses, in the cycle after the 24th synced falling edge is detected.
- With address 111, validA and validB pulse together and both channels load the same raw field, each with its own SIGN applied.
- The valid and frameErr strobes are never asserted for the same frame.
- Reset mid-frame discards the partial frame with no strobe. After release the FSM waits for a fresh sSync falling edge.

Test Plan:
Common configuration: DATA_WIDTH=14, SIGN_A=1, SIGN_B=0, SYNC_STAGES=2. The source is the team's DAC driver or a bench model with sclk = clk/4.

1. Frame 0x007FFC (cmd 000, addr A) -> one validA pulse; dataA = 0x3FFF (−1); command = 000; dataB unchanged; no frameErr.
2. Frame 0x1148D0 (cmd 010, addr B) -> validB pulse; dataB = 0x1234; validA stays low.
3. Frame 0x1F0000 (cmd 011, addr 111) -> validA and validB pulse in the same cycle; dataA = 0x2000; dataB = 0x0000.
4. Send 10 bits of any frame, then raise dacSync -> frameErr pulse; no valid pulse; dataA/dataB keep their prior values. A following valid frame then decodes correctly.
5. Frame 0x120000 (addr 010), then a frame with cmd 111 -> frameErr pulses for each and no valid pulses. Separately, a valid frame followed by 5 extra sclk edges before dacSync rises -> exactly one valid pulse and no frameErr.
6. Assert reset after bit 12 of a frame while dacSync stays low, then release -> no strobes during the remainder of that frame. The next complete frame, 0x007FFC, gives dataA = 0x3FFF.
